lzd_normalizer_seq: RTL

- Multi-cycle, parametrised leading-zero detector and normaliser for the FP adder datapath.
- Accepts a WIDTH-bit mantissa over a valid/ready handshake and scans it CHUNK bits per cycle from the MSB.
- Returns the leading-zero count, the left-justified (normalised) mantissa and an all-zero flag.
- Sits after the mantissa add/subtract stage and feeds the exponent-adjust stage. It replaces single-cycle combinational LZD use where timing is tight.

---
 rtl/lzd_normalizer_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lzd_normalizer_seq.sv
// Multi-cycle leading-zero detector / normaliser for the FP adder datapath.
// Scans a WIDTH-bit mantissa CHUNK bits per cycle from the MSB and returns the
// leading-zero count, the left-justified mantissa and an all-zero flag.
// Optional macro LZD_EARLY_ZERO_EN: an all-zero input (enable=1) skips the
// scan and completes one cycle after accept with the same result.
module lzd_normalizer_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] norm,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  // Number of chunks and the padded scan-register width.
  localparam int N     = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int SW    = N * CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_norm;
  logic             r_zero;

  logic             w_accept;
  logic             w_out_hs;
  logic [CHUNK-1:0] w_top;
  logic             w_top_zero;
  logic [CNT_W-1:0] w_pos;
  logic [SW-1:0]    w_shifted;
  logic [WIDTH-1:0] w_norm_found;
  logic             w_last_chunk;
  logic             w_early_zero;

  assign w_accept     = in_valid && (r_state == S_IDLE);
  assign w_out_hs     = out_ready && (r_state == S_DONE);
  assign w_top        = r_sh[SW-1 -: CHUNK];
  assign w_top_zero   = (w_top == '0);
  assign w_last_chunk = (r_idx == IDX_W'(N - 1));
  assign w_shifted    = r_sh << w_pos;
  // Top WIDTH bits of the shifted register; padding bits drop off the bottom.
  assign w_norm_found = WIDTH'(w_shifted >> (SW - WIDTH));

`ifdef LZD_EARLY_ZERO_EN
  assign w_early_zero = (num == '0);
`else
  assign w_early_zero = 1'b0;
`endif

  // Priority-encode the first 1 in the top chunk (0 = chunk MSB).
  always_comb begin
    w_pos = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (w_top[CHUNK-1-i]) w_pos = CNT_W'(i);
    end
  end

  // Next-state logic for the IDLE / SCAN / DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!enable || w_early_zero) w_state_nxt = S_DONE;
          else                         w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!w_top_zero || w_last_chunk) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Scan datapath: shift register, running count and chunk index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_sh  <= SW'(num) << (SW - WIDTH);
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_state == S_SCAN && w_top_zero) begin
      r_sh  <= r_sh << CHUNK;
      r_cnt <= r_cnt + CNT_W'(CHUNK);
      r_idx <= r_idx + 1'b1;
    end
  end

  // Result registers, loaded when the sequencer enters DONE and held there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_norm  <= '0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      if (!enable) begin
        r_count <= '0;
        r_norm  <= num;
        r_zero  <= 1'b0;
      end else if (w_early_zero) begin
        r_count <= CNT_W'(WIDTH);
        r_norm  <= '0;
        r_zero  <= 1'b1;
      end
    end else if (r_state == S_SCAN) begin
      if (!w_top_zero) begin
        r_count <= r_cnt + w_pos;
        r_norm  <= w_norm_found;
        r_zero  <= 1'b0;
      end else if (w_last_chunk) begin
        // Saturate at WIDTH rather than N*CHUNK when padding is present.
        r_count <= CNT_W'(WIDTH);
        r_norm  <= '0;
        r_zero  <= 1'b1;
      end
    end else if (w_out_hs) begin
      r_count <= r_count;
      r_norm  <= r_norm;
      r_zero  <= r_zero;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign count     = r_count;
  assign norm      = r_norm;
  assign zero      = r_zero;

endmodule
